// File: rtl/ahbl_gpio_regs.sv
// ahbl_gpio_regs: zero-wait AHB-Lite register file in front of the GPIO pad wrapper.
// Per-pin edge interrupts (IM/IEDGE/IS, IRQ) are built only when GPIO_EDGE_IRQ_EN is defined.
module ahbl_gpio_regs #(
    parameter int PINS = 16
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            HSEL,
    input  logic [7:0]      HADDR,
    input  logic [1:0]      HTRANS,
    input  logic            HWRITE,
    input  logic            HREADY,
    input  logic [31:0]     HWDATA,
    output logic [31:0]     HRDATA,
    output logic            HREADYOUT,
    output logic            HRESP,
    input  logic [PINS-1:0] WGPIODIN,
    output logic [PINS-1:0] WGPIODOUT,
    output logic [PINS-1:0] WGPIODIR,
    output logic [PINS-1:0] WGPIOPU,
    output logic [PINS-1:0] WGPIOPD,
    output logic            IRQ
);

    localparam logic [5:0] OFF_DATAI = 6'h00;
    localparam logic [5:0] OFF_DATAO = 6'h01;
    localparam logic [5:0] OFF_DIR   = 6'h02;
    localparam logic [5:0] OFF_PU    = 6'h03;
    localparam logic [5:0] OFF_PD    = 6'h04;
    localparam logic [5:0] OFF_IM    = 6'h05;
    localparam logic [5:0] OFF_IEDGE = 6'h06;
    localparam logic [5:0] OFF_IS    = 6'h07;

    logic            valid_r;
    logic            write_r;
    logic [5:0]      addr_r;
    logic [PINS-1:0] dout_r;
    logic [PINS-1:0] dir_r;
    logic [PINS-1:0] pu_r;
    logic [PINS-1:0] pd_r;
    logic [PINS-1:0] sync1_r;
    logic [PINS-1:0] sync2_r;
    logic            wr_dout_s;
    logic            wr_dir_s;
    logic            wr_pu_s;
    logic            wr_pd_s;
    logic [31:0]     rdata_s;
    logic            unused_s;
`ifdef GPIO_EDGE_IRQ_EN
    logic [PINS-1:0] im_r;
    logic [PINS-1:0] iedge_r;
    logic [PINS-1:0] is_r;
    logic [PINS-1:0] prev_r;
    logic [PINS-1:0] edge_s;
    logic [PINS-1:0] is_clr_s;
    logic            wr_im_s;
    logic            wr_iedge_s;
    logic            wr_is_s;
`endif

    // Address-phase capture; a non-transfer cycle drops the valid flag
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_r <= 1'b0;
            write_r <= 1'b0;
            addr_r  <= 6'h00;
        end else if (HSEL && HREADY && HTRANS[1]) begin
            valid_r <= 1'b1;
            write_r <= HWRITE;
            addr_r  <= HADDR[7:2];
        end else begin
            valid_r <= 1'b0;
        end
    end

    // Data-phase write strobes decoded from the latched address
    always_comb begin
        wr_dout_s  = 1'b0;
        wr_dir_s   = 1'b0;
        wr_pu_s    = 1'b0;
        wr_pd_s    = 1'b0;
`ifdef GPIO_EDGE_IRQ_EN
        wr_im_s    = 1'b0;
        wr_iedge_s = 1'b0;
        wr_is_s    = 1'b0;
`endif
        if (valid_r && write_r) begin
            case (addr_r)
                OFF_DATAO: wr_dout_s  = 1'b1;
                OFF_DIR:   wr_dir_s   = 1'b1;
                OFF_PU:    wr_pu_s    = 1'b1;
                OFF_PD:    wr_pd_s    = 1'b1;
`ifdef GPIO_EDGE_IRQ_EN
                OFF_IM:    wr_im_s    = 1'b1;
                OFF_IEDGE: wr_iedge_s = 1'b1;
                OFF_IS:    wr_is_s    = 1'b1;
`endif
                default:   wr_dout_s  = 1'b0;
            endcase
        end else begin
            wr_dout_s = 1'b0;
        end
    end

    // Control registers feeding the pad wrapper
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dout_r <= {PINS{1'b0}};
            dir_r  <= {PINS{1'b0}};
            pu_r   <= {PINS{1'b0}};
            pd_r   <= {PINS{1'b0}};
        end else begin
            if (wr_dout_s) dout_r <= HWDATA[PINS-1:0];
            if (wr_dir_s)  dir_r  <= HWDATA[PINS-1:0];
            if (wr_pu_s)   pu_r   <= HWDATA[PINS-1:0];
            if (wr_pd_s)   pd_r   <= HWDATA[PINS-1:0];
        end
    end

    // Two-flop synchroniser for the asynchronous pad input
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_r <= {PINS{1'b0}};
            sync2_r <= {PINS{1'b0}};
        end else begin
            sync1_r <= WGPIODIN;
            sync2_r <= sync1_r;
        end
    end

`ifdef GPIO_EDGE_IRQ_EN
    assign edge_s   = (iedge_r & sync2_r & ~prev_r) | (~iedge_r & ~sync2_r & prev_r);
    assign is_clr_s = wr_is_s ? HWDATA[PINS-1:0] : {PINS{1'b0}};

    // Interrupt state: an edge in the same cycle as a W1C keeps the bit set
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            prev_r  <= {PINS{1'b0}};
            im_r    <= {PINS{1'b0}};
            iedge_r <= {PINS{1'b0}};
            is_r    <= {PINS{1'b0}};
        end else begin
            prev_r <= sync2_r;
            is_r   <= (is_r & ~is_clr_s) | edge_s;
            if (wr_im_s)    im_r    <= HWDATA[PINS-1:0];
            if (wr_iedge_s) iedge_r <= HWDATA[PINS-1:0];
        end
    end

    assign IRQ = |(is_r & im_r);
`else
    assign IRQ = 1'b0;
`endif

    // Read mux; upper bits beyond PINS stay zero
    always_comb begin
        rdata_s = 32'd0;
        if (valid_r && !write_r) begin
            case (addr_r)
                OFF_DATAI: rdata_s[PINS-1:0] = sync2_r;
                OFF_DATAO: rdata_s[PINS-1:0] = dout_r;
                OFF_DIR:   rdata_s[PINS-1:0] = dir_r;
                OFF_PU:    rdata_s[PINS-1:0] = pu_r;
                OFF_PD:    rdata_s[PINS-1:0] = pd_r;
`ifdef GPIO_EDGE_IRQ_EN
                OFF_IM:    rdata_s[PINS-1:0] = im_r;
                OFF_IEDGE: rdata_s[PINS-1:0] = iedge_r;
                OFF_IS:    rdata_s[PINS-1:0] = is_r;
`endif
                default:   rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign HRDATA    = rdata_s;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign WGPIODOUT = dout_r;
    assign WGPIODIR  = dir_r;
    assign WGPIOPU   = pu_r;
    assign WGPIOPD   = pd_r;

    // Address byte lanes, HTRANS[0] and upper write-data bits carry no meaning here
    assign unused_s = &{1'b0, HADDR[1:0], HTRANS[0], HWDATA};

endmodule

// File: tb/tb_ahbl_gpio_regs.sv
// tb_ahbl_gpio_regs: directed bench for ahbl_gpio_regs (PINS=16); read expectations go through a scoreboard queue.
// Interrupt checks follow GPIO_EDGE_IRQ_EN the same way the design does.
module tb_ahbl_gpio_regs;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [7:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [15:0] WGPIODIN;
    logic [15:0] WGPIODOUT;
    logic [15:0] WGPIODIR;
    logic [15:0] WGPIOPU;
    logic [15:0] WGPIOPD;
    logic        IRQ;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    ahbl_gpio_regs #(.PINS(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .WGPIODIN(WGPIODIN), .WGPIODOUT(WGPIODOUT),
        .WGPIODIR(WGPIODIR), .WGPIOPU(WGPIOPU), .WGPIOPD(WGPIOPD), .IRQ(IRQ)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic read_check(input logic [7:0] a, input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        chk(tag_q.pop_front(), HRDATA, exp_q.pop_front());
    endtask

    initial begin
        HRESETn = 1'b0; HSEL = 1'b0; HADDR = 8'h00; HTRANS = 2'b00; HWRITE = 1'b0;
        HREADY = 1'b1; HWDATA = 32'd0; WGPIODIN = 16'h0000;
        cyc(3);
        chk("rst_dout", {16'd0, WGPIODOUT}, 32'd0);
        chk("rst_dir", {16'd0, WGPIODIR}, 32'd0);
        chk("rst_pu", {16'd0, WGPIOPU}, 32'd0);
        chk("rst_pd", {16'd0, WGPIOPD}, 32'd0);
        chk("rst_irq", {31'd0, IRQ}, 32'd0);
        HRESETn = 1'b1;
        cyc(1);
        chk("hreadyout", {31'd0, HREADYOUT}, 32'd1);
        chk("hresp", {31'd0, HRESP}, 32'd0);
        for (int i = 0; i < 8; i++) read_check(8'(i * 4), 32'd0, $sformatf("rst_rd_%0d", i));

        // Control register writes and readback
        ahb_write(8'h04, 32'h0000A5A5);
        chk("w_dout", {16'd0, WGPIODOUT}, 32'h0000A5A5);
        ahb_write(8'h08, 32'h000000FF);
        chk("w_dir", {16'd0, WGPIODIR}, 32'h000000FF);
        ahb_write(8'h0C, 32'h00000F0F);
        chk("w_pu", {16'd0, WGPIOPU}, 32'h00000F0F);
        ahb_write(8'h10, 32'h0000F0F0);
        chk("w_pd", {16'd0, WGPIOPD}, 32'h0000F0F0);
        read_check(8'h04, 32'h0000A5A5, "rb_dout");
        read_check(8'h08, 32'h000000FF, "rb_dir");
        read_check(8'h0C, 32'h00000F0F, "rb_pu");
        read_check(8'h10, 32'h0000F0F0, "rb_pd");

        // Back-to-back write then read of the same register
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 8'h04;
        @(posedge HCLK); #1;
        HWDATA = 32'h00005A5A; HWRITE = 1'b0; HADDR = 8'h04;
        exp_q.push_back(32'h00005A5A);
        tag_q.push_back("b2b_rd");
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        chk(tag_q.pop_front(), HRDATA, exp_q.pop_front());
        chk("b2b_dout", {16'd0, WGPIODOUT}, 32'h00005A5A);

        // Input synchroniser latency
        WGPIODIN = 16'h1234;
        read_check(8'h00, 32'h00000000, "datai_lat1");
        read_check(8'h00, 32'h00001234, "datai_lat2");
        read_check(8'h00, 32'h00001234, "datai_hold");

`ifdef GPIO_EDGE_IRQ_EN
        ahb_write(8'h14, 32'h00000001);
        ahb_write(8'h18, 32'h00000001);
        WGPIODIN = 16'h1235;
        cyc(2);
        chk("irq_cyc2", {31'd0, IRQ}, 32'd0);
        cyc(1);
        chk("irq_cyc3", {31'd0, IRQ}, 32'd1);
        read_check(8'h1C, 32'h00000001, "is_rise");
        ahb_write(8'h1C, 32'h00000001);
        chk("irq_clr", {31'd0, IRQ}, 32'd0);
        read_check(8'h1C, 32'h00000000, "is_clr");
        ahb_write(8'h18, 32'h00000000);
        WGPIODIN = 16'h1234;
        cyc(3);
        chk("irq_fall", {31'd0, IRQ}, 32'd1);
        read_check(8'h1C, 32'h00000001, "is_fall");
        WGPIODIN = 16'h1235;
        cyc(3);
        ahb_write(8'h1C, 32'h00000001);
        read_check(8'h1C, 32'h00000000, "is_rise_ignored");
        WGPIODIN = 16'h1234;
        cyc(1);
        ahb_write(8'h1C, 32'h00000001);
        read_check(8'h1C, 32'h00000001, "is_set_wins");
        chk("irq_set_wins", {31'd0, IRQ}, 32'd1);
        read_check(8'h14, 32'h00000001, "rb_im");
        read_check(8'h18, 32'h00000000, "rb_iedge");
`else
        ahb_write(8'h14, 32'hFFFFFFFF);
        ahb_write(8'h18, 32'hFFFFFFFF);
        ahb_write(8'h1C, 32'hFFFFFFFF);
        WGPIODIN = 16'h1235;
        cyc(3);
        WGPIODIN = 16'h1234;
        cyc(3);
        read_check(8'h14, 32'h00000000, "im_absent");
        read_check(8'h18, 32'h00000000, "iedge_absent");
        read_check(8'h1C, 32'h00000000, "is_absent");
        chk("irq_tied", {31'd0, IRQ}, 32'd0);
`endif

        // Writes to read-only and unmapped offsets change nothing
        ahb_write(8'h00, 32'hFFFFFFFF);
        chk("hresp_ro", {31'd0, HRESP}, 32'd0);
        ahb_write(8'h40, 32'hFFFFFFFF);
        chk("hresp_unmap", {31'd0, HRESP}, 32'd0);
        read_check(8'h40, 32'h00000000, "rd_unmap40");
        read_check(8'h20, 32'h00000000, "rd_unmap20");
        read_check(8'h00, 32'h00001234, "datai_after_wr");
        read_check(8'h04, 32'h00005A5A, "dout_kept");
        read_check(8'h08, 32'h000000FF, "dir_kept");
        read_check(8'h0C, 32'h00000F0F, "pu_kept");
        read_check(8'h10, 32'h0000F0F0, "pd_kept");

        // Upper bits ignored; overlapping PU/PD passes through
        ahb_write(8'h0C, 32'hFFFFFFFF);
        read_check(8'h0C, 32'h0000FFFF, "pu_upper");
        chk("pu_overlap", {16'd0, WGPIOPU}, 32'h0000FFFF);
        chk("pd_overlap", {16'd0, WGPIOPD}, 32'h0000F0F0);

        // Reset during a DATAO write data phase drops the write
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 8'h04;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h00001111;
        #2 HRESETn = 1'b0;
        @(posedge HCLK); #1;
        chk("midrst_dout", {16'd0, WGPIODOUT}, 32'd0);
        chk("midrst_dir", {16'd0, WGPIODIR}, 32'd0);
        HRESETn = 1'b1;
        cyc(2);
        chk("postrst_dout", {16'd0, WGPIODOUT}, 32'd0);
        read_check(8'h04, 32'h00000000, "postrst_rd_dout");
        read_check(8'h0C, 32'h00000000, "postrst_rd_pu");
        chk("postrst_irq", {31'd0, IRQ}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
